pipe_stage_elastic: RTL and testbench

Parametrised, elastic successor to the fixed per-stage pipeline registers (fetch/decode/execute/mem). A 2-entry skid-buffered pipeline stage carrying an opaque WIDTH-bit payload. Upstream and downstream use valid/ready handshakes. Hazard-control inputs stall, bubble and flush the stage, and saturating counters record stall cycles and killed entries. It is instantiated between any two pipeline stages of the core.

---
 rtl/pipe_stage_elastic.sv | 132 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - two-entry skid-buffered elastic pipeline stage with hazard control
module pipe_stage_elastic #(
   parameter int unsigned      WIDTH      = 64,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
   parameter int unsigned      CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             out_ready_i,
   input  logic             stall_i,
   input  logic             bubble_i,
   input  logic             flush_i,
   output logic [1:0]       occ_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] kill_cnt_o
);

   // Occupancy doubles as the state: main holds the head, skid the second entry.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } occ_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   occ_e             occ_q, occ_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

   logic             push;
   logic             pop;
   logic [1:0]       kill_add;
   logic [CNT_W:0]   kill_sum;

   // Handshake outputs: a bubble or flush cycle never accepts new data, and
   // nothing is offered downstream while held or in reset.
   assign in_ready_o  = !rst_i && (occ_q != S_FULL) && !stall_i && !flush_i && !bubble_i;
   assign out_valid_o = !rst_i && (occ_q != S_EMPTY) && !stall_i;
   assign out_data_o  = main_q;
   assign occ_o       = occ_q;
   assign stall_cnt_o = stall_cnt_q;
   assign kill_cnt_o  = kill_cnt_q;

   assign push = in_valid_i && in_ready_o;
   assign pop  = out_valid_o && out_ready_i && !flush_i && !bubble_i;

   // Next-state for occupancy and storage, priority flush > stall > bubble > normal.
   always_comb begin
      occ_d  = occ_q;
      main_d = main_q;
      skid_d = skid_q;
      if (flush_i) begin
         // Contents become don't-care, so storage simply holds.
         occ_d = S_EMPTY;
      end else if (stall_i) begin
         occ_d = occ_q;
      end else if (bubble_i) begin
         main_d = BUBBLE_VAL;
         occ_d  = S_ONE;
      end else begin
         case (occ_q)
            S_EMPTY: begin
               if (push) begin
                  main_d = in_data_i;
                  occ_d  = S_ONE;
               end
            end
            S_ONE: begin
               if (push && pop) begin
                  main_d = in_data_i;
               end else if (push) begin
                  skid_d = in_data_i;
                  occ_d  = S_FULL;
               end else if (pop) begin
                  occ_d = S_EMPTY;
               end
            end
            S_FULL: begin
               // in_ready_o is low here, so only a pop can happen.
               if (pop) begin
                  main_d = skid_q;
                  occ_d  = S_ONE;
               end
            end
            default: begin
               occ_d = S_EMPTY;
            end
         endcase
      end
   end

   // Saturating performance counters; kills count entries thrown away by flush or bubble.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      kill_add    = 2'd0;
      if (flush_i || (!stall_i && bubble_i)) begin
         kill_add = occ_q;
      end
      if (!flush_i && stall_i && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      kill_sum   = {1'b0, kill_cnt_q} + {{(CNT_W-1){1'b0}}, kill_add};
      kill_cnt_d = kill_sum[CNT_W] ? CNT_MAX : kill_sum[CNT_W-1:0];
   end

   // State register with synchronous reset; reset drops entries without counting kills.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q       <= S_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         stall_cnt_q <= '0;
         kill_cnt_q  <= '0;
      end else begin
         occ_q       <= occ_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         stall_cnt_q <= stall_cnt_d;
         kill_cnt_q  <= kill_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

   localparam int          W    = 16;
   localparam int          CW   = 4;
   localparam int          CMAX = 15;
   localparam logic [15:0] BUB  = 16'hB0B0;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          in_valid_i;
   logic [W-1:0]  in_data_i;
   logic          in_ready_o;
   logic          out_valid_o;
   logic [W-1:0]  out_data_o;
   logic          out_ready_i;
   logic          stall_i;
   logic          bubble_i;
   logic          flush_i;
   logic [1:0]    occ_o;
   logic [CW-1:0] stall_cnt_o;
   logic [CW-1:0] kill_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference contents of the stage, oldest first; also the expected delivery order.
   logic [W-1:0] exp_q[$];
   int           m_stall = 0;
   int           m_kill  = 0;

   pipe_stage_elastic #(.WIDTH(W), .BUBBLE_VAL(BUB), .CNT_W(CW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .stall_i     (stall_i),
      .bubble_i    (bubble_i),
      .flush_i     (flush_i),
      .occ_o       (occ_o),
      .stall_cnt_o (stall_cnt_o),
      .kill_cnt_o  (kill_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus: drive after the falling edge, check, then advance the model.
   task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                        input logic rdy, input logic st, input logic bub, input logic fl);
      int   occ;
      logic exp_rdy;
      logic exp_vld;
      @(negedge clk_i);
      rst_i       = r;
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = rdy;
      stall_i     = st;
      bubble_i    = bub;
      flush_i     = fl;
      #1;
      occ = exp_q.size();
      if (r) begin
         chk("rst_in_ready", 32'(in_ready_o), 32'd0);
         chk("rst_out_valid", 32'(out_valid_o), 32'd0);
         exp_q.delete();
         m_stall = 0;
         m_kill  = 0;
      end else begin
         exp_rdy = (occ < 2) && !st && !fl && !bub;
         exp_vld = (occ != 0) && !st;
         chk("occ", 32'(occ_o), 32'(occ));
         chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
         chk("out_valid", 32'(out_valid_o), 32'(exp_vld));
         chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
         chk("kill_cnt", 32'(kill_cnt_o), 32'(m_kill));
         if (fl) begin
            m_kill = sat(m_kill + occ);
            exp_q.delete();
         end else if (st) begin
            m_stall = sat(m_stall + 1);
         end else if (bub) begin
            m_kill = sat(m_kill + occ);
            exp_q  = {BUB};
         end else if (v && exp_rdy) begin
            exp_q.push_back(d);
         end
      end
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 1'b0, '0, rdy, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic put(input logic [W-1:0] d, input logic rdy);
      cycle(1'b0, 1'b1, d, rdy, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: whenever a head is presented, compare it with the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk_i);
         #2;
         if (!rst_i && out_valid_o && !flush_i && !bubble_i) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL head_unexpected: got %0h expected no entry at %0t", out_data_o, $time);
            end else begin
               chk("head", 32'(out_data_o), 32'(exp_q[0]));
               if (out_ready_i) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      chk("reset_main", 32'(out_data_o), 32'd0);

      // Fill/drain at full rate.
      put(16'h00A1, 1'b1);
      put(16'h00A2, 1'b1);
      chk("fd_occ", 32'(occ_o), 32'd1);
      put(16'h00A3, 1'b1);
      chk("fd_ready", 32'(in_ready_o), 32'd1);
      idle(1'b1);
      idle(1'b1);

      // Backpressure fills the skid entry.
      put(16'h0011, 1'b0);
      put(16'h0022, 1'b0);
      put(16'h0033, 1'b0);
      chk("bp_occ", 32'(occ_o), 32'd2);
      chk("bp_head", 32'(out_data_o), 32'h11);
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      chk("bp_empty", 32'(occ_o), 32'd0);

      // Stall while full, then bubble.
      put(16'h0011, 1'b0);
      put(16'h0022, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0044, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("st_cnt", 32'(stall_cnt_o), 32'd3);
      chk("st_occ", 32'(occ_o), 32'd2);
      chk("st_head", 32'(out_data_o), 32'h11);
      cycle(1'b0, 1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("bub_ready", 32'(in_ready_o), 32'd0);
      idle(1'b0);
      chk("bub_occ", 32'(occ_o), 32'd1);
      chk("bub_head", 32'(out_data_o), 32'(BUB));
      chk("bub_kill", 32'(kill_cnt_o), 32'd2);
      idle(1'b1);

      // Flush beats stall.
      put(16'h0066, 1'b0);
      cycle(1'b0, 1'b1, 16'h0077, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(1'b0);
      chk("fl_occ", 32'(occ_o), 32'd0);
      chk("fl_kill", 32'(kill_cnt_o), 32'd3);
      chk("fl_stall", 32'(stall_cnt_o), 32'd3);

      // Reset while full.
      put(16'h0088, 1'b0);
      put(16'h0099, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      chk("rf_occ", 32'(occ_o), 32'd0);
      chk("rf_stall", 32'(stall_cnt_o), 32'd0);
      chk("rf_kill", 32'(kill_cnt_o), 32'd0);

      // Stall counter saturation.
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("sat_stall", 32'(stall_cnt_o), 32'd15);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk("sat_hold", 32'(stall_cnt_o), 32'd15);

      // Randomized traffic against the reference model.
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 299) == 0),
               ($urandom_range(0, 3) != 0),
               W'($urandom),
               ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 19) == 0));
      end
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("final_empty", 32'(occ_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
